// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Byte buffer behind the UART receiver. Each rising edge of the receiver's
//   data_ready strobe pushes {parity_err, byte} into a circular FIFO. The
//   consumer reads through a first-word-fall-through valid/ready port.
//   Optional build macro: PARITY_DROP_EN
//     defined   : bytes flagged with a parity error are discarded and counted
//                 in parity_drops (saturating); rd_parity_err is tied to 0.
//     undefined : every byte is stored with its flag; parity_drops is tied to 0.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_data         byte from the receiver
//   wr_strobe       receiver data_ready (level; only its rising edge pushes)
//   wr_parity_err   receiver parity flag, captured with wr_data
//   rd_ready        consumer takes the head entry this cycle
//   rd_valid        FIFO holds at least one entry
//   rd_data         head byte (0 while empty)
//   rd_parity_err   parity flag of the head byte (0 while empty)
//   count           entries held, 0..DEPTH
//   full            count == DEPTH
//   almost_full     count >= AFULL_LEVEL
//   overflow        sticky: a byte was dropped because the FIFO was full
//   clear_overflow  clears overflow (a same-cycle drop wins)
//   parity_drops    saturating count of bytes discarded for parity
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_data,
    input  logic                     wr_strobe,
    input  logic                     wr_parity_err,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [7:0]               parity_drops
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LEVEL);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          strobe_q;
    logic          push, store, pop, accept, drop;
    logic [8:0]    head;

    // The receiver may hold data_ready for many cycles; only its edge counts.
    assign push = wr_strobe & ~strobe_q;

`ifdef PARITY_DROP_EN
    assign store = push & ~wr_parity_err;
`else
    assign store = push;
`endif

    assign rd_valid    = (count != '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AFULL_C);
    assign pop         = rd_valid & rd_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign accept      = store & (~full | pop);
    assign drop        = store & full & ~pop;

    // Head comes from registered state only; gated so it reads 0 while empty.
    assign head    = mem[rd_ptr];
    assign rd_data = rd_valid ? head[7:0] : 8'h00;

`ifdef PARITY_DROP_EN
    assign rd_parity_err = 1'b0;
`else
    assign rd_parity_err = rd_valid & head[8];
`endif

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {wr_parity_err, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            strobe_q <= wr_strobe;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

`ifdef PARITY_DROP_EN
    always_ff @(posedge clk) begin
        if (rst)
            parity_drops <= 8'h00;
        else if (push && wr_parity_err && parity_drops != 8'hFF)
            parity_drops <= parity_drops + 8'h01;
    end
`else
    assign parity_drops = 8'h00;
`endif

endmodule
